// File: rtl/tcdm_arb_pkg.sv
// rtl/tcdm_arb_pkg.sv - shared widths, ID width helper and TCDM request/response types
package tcdm_arb_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    function automatic int id_width(input int nb_in);
        return (nb_in > 1) ? $clog2(nb_in) : 1;
    endfunction

    typedef struct packed {
        logic [ARB_AW-1:0]   add;
        logic                wen;
        logic [ARB_DW/8-1:0] be;
        logic [ARB_DW-1:0]   data;
    } tcdm_req_t;

    typedef struct packed {
        logic              r_valid;
        logic [ARB_DW-1:0] r_data;
    } tcdm_rsp_t;

endpackage

// File: rtl/tcdm_rr_arbiter_if.sv
// rtl/tcdm_rr_arbiter_if.sv - requester-side and slave-side TCDM bus bundle for the arbiter
interface tcdm_rr_arbiter_if
    import tcdm_arb_pkg::*;
#(
    parameter int NB_IN = 4,
    parameter int AW    = ARB_AW,
    parameter int DW    = ARB_DW
) ();

    logic [NB_IN-1:0]              in_req_i;
    logic [NB_IN-1:0][AW-1:0]      in_add_i;
    logic [NB_IN-1:0]              in_wen_i;
    logic [NB_IN-1:0][DW/8-1:0]    in_be_i;
    logic [NB_IN-1:0][DW-1:0]      in_data_i;
    logic [NB_IN-1:0]              in_gnt_o;
    logic [NB_IN-1:0]              in_r_valid_o;
    logic [DW-1:0]                 in_r_data_o;

    logic                          out_req_o;
    logic [AW-1:0]                 out_add_o;
    logic                          out_wen_o;
    logic [DW/8-1:0]               out_be_o;
    logic [DW-1:0]                 out_data_o;
    logic                          out_gnt_i;
    logic                          out_r_valid_i;
    logic [DW-1:0]                 out_r_data_i;

    logic                          busy_o;
    logic                          err_o;

    modport slave (
        input  in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i,
        input  out_gnt_i, out_r_valid_i, out_r_data_i,
        output in_gnt_o, in_r_valid_o, in_r_data_o,
        output out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o,
        output busy_o, err_o
    );

    modport master (
        output in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i,
        output out_gnt_i, out_r_valid_i, out_r_data_i,
        input  in_gnt_o, in_r_valid_o, in_r_data_o,
        input  out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o,
        input  busy_o, err_o
    );

endinterface

// File: rtl/tcdm_arb_id_fifo.sv
// rtl/tcdm_arb_id_fifo.sv - in-order FIFO of granted requester IDs awaiting a response
module tcdm_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/tcdm_rr_arbiter.sv
// rtl/tcdm_rr_arbiter.sv - round-robin N:1 TCDM arbiter with stall lock and in-order response routing
module tcdm_rr_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int NB_IN     = 4,
    parameter int AW        = ARB_AW,
    parameter int DW        = ARB_DW,
    parameter int MAX_OUTST = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    tcdm_rr_arbiter_if.slave   bus
);

    localparam int ID_W = id_width(NB_IN);

    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_lock_id;
    logic            r_lock;
    logic            r_err;

    logic [ID_W-1:0] w_winner;
    logic [ID_W-1:0] w_head;
    logic            w_any;
    logic            w_issue;
    logic            w_grant;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;

    // A locked requester that drops its request simply yields no issue this cycle.
    always_comb begin
        logic [ID_W-1:0] w_cand;
        w_winner = r_rr_ptr;
        w_any    = 1'b0;
        w_cand   = '0;
        if (r_lock) begin
            w_winner = r_lock_id;
            w_any    = bus.in_req_i[r_lock_id];
        end else begin
            for (int k = 0; k < NB_IN; k++) begin
                w_cand = ID_W'((int'(r_rr_ptr) + k) % NB_IN);
                if (!w_any && bus.in_req_i[w_cand]) begin
                    w_any    = 1'b1;
                    w_winner = w_cand;
                end
            end
        end
    end

    assign w_issue = w_any & ~w_full & ~rst_i;
    assign w_grant = w_issue & bus.out_gnt_i;
    assign w_pop   = bus.out_r_valid_i & ~w_empty & ~rst_i;

    logic [AW-1:0]   w_add;
    logic [DW/8-1:0] w_be;
    logic [DW-1:0]   w_data;

    assign w_add  = bus.in_add_i[w_winner];
    assign w_be   = bus.in_be_i[w_winner];
    assign w_data = bus.in_data_i[w_winner];

    assign bus.out_req_o    = w_issue;
    assign bus.out_add_o    = w_issue ? w_add  : '0;
    assign bus.out_wen_o    = w_issue & bus.in_wen_i[w_winner];
    assign bus.out_be_o     = w_issue ? w_be   : '0;
    assign bus.out_data_o   = w_issue ? w_data : '0;
    assign bus.in_gnt_o     = w_grant ? (NB_IN'(1) << w_winner) : '0;
    assign bus.in_r_valid_o = w_pop   ? (NB_IN'(1) << w_head)   : '0;
    assign bus.in_r_data_o  = bus.out_r_data_i;
    assign bus.busy_o       = ~w_empty;
    assign bus.err_o        = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_err     <= 1'b0;
        end else begin
            r_lock <= w_issue & ~bus.out_gnt_i;
            if (w_issue & ~bus.out_gnt_i) r_lock_id <= w_winner;
            if (w_grant) r_rr_ptr <= (w_winner == ID_W'(NB_IN - 1)) ? '0 : w_winner + 1'b1;
            if (bus.out_r_valid_i & w_empty) r_err <= 1'b1;
        end
    end

    tcdm_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_grant),
        .data_i  (w_winner),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

endmodule

// File: doc/tcdm_rr_arbiter.md
Name: tcdm_rr_arbiter

Overview:
- Shares one TCDM slave port (the testbench TCDM memory model or a real bank) among NB_IN requesters, e.g. RedMulE streamer ports plus a debug/loader master.
- Round-robin arbitration with a locked selection while the slave stalls, and an in-order outstanding-ID FIFO that routes r_valid/r_data back to the issuing requester.
- Tolerates slave grant delays of any length and any response latency of at least 1 cycle.

Parameters:
- NB_IN, 4, number of requester ports (>=2).
- AW, 32, address width.
- DW, 32, data width (BE width = DW/8).
- MAX_OUTST, 2, maximum granted-but-unanswered transactions (ID FIFO depth, >=1).
- ID_W, $clog2(NB_IN), requester index width (package constant derived per instance).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- in_req_i  in  NB_IN  per-requester request.
- in_add_i  in  NB_IN x AW  per-requester byte address.
- in_wen_i  in  NB_IN  1 = read, 0 = write.
- in_be_i  in  NB_IN x DW/8  byte enables.
- in_data_i  in  NB_IN x DW  write data.
- in_gnt_o  out  NB_IN  per-requester grant.
- in_r_valid_o  out  NB_IN  per-requester response valid.
- in_r_data_o  out  DW  response data, broadcast to all requesters.
- out_req_o  out  1  slave request.
- out_add_o  out  AW  slave address.
- out_wen_o  out  1  slave read/write select.
- out_be_o  out  DW/8  slave byte enables.
- out_data_o  out  DW  slave write data.
- out_gnt_i  in  1  slave grant.
- out_r_valid_i  in  1  slave response valid.
- out_r_data_i  in  DW  slave response data.
- busy_o  out  1  ID FIFO not empty.
- err_o  out  1  sticky: response received with the ID FIFO empty.

Behaviour:
- Reset (rst_i high at a clock edge):
  - rr_ptr=0, lock=0, FIFO empty, err_o=0.
  - All outputs 0, including out_req_o, in_gnt_o, in_r_valid_o, busy_o.
  - Reset mid-transaction drops outstanding IDs; any late responses then raise err_o.
- Selection is combinational:
  - If lock=1, winner = locked_id.
  - Otherwise winner = first index i with in_req_i[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NB_IN.
- out_req_o = any eligible request AND FIFO not full.
  - Full FIFO blocks new issue even if a pop occurs in the same cycle.
  - out_add/wen/be/data are muxed from the winner.
  - Outputs are 0 when out_req_o=0.
- in_gnt_o[winner] = out_req_o & out_gnt_i; all other grants are 0. No registered stage; handshake latency is 0.
- Lock:
  - Set when out_req_o=1 and out_gnt_i=0; locked_id = winner.
  - Cleared on the grant cycle.
  - The locked requester must keep in_req_i high (TCDM protocol). If it drops, lock clears the next cycle and no grant is issued to it.
- On grant: push winner ID into the FIFO, and set rr_ptr = winner+1, wrapping NB_IN-1 to 0.
- Response:
  - out_r_valid_i=1 with FIFO not empty → pop head h; in_r_valid_o[h]=1 in the same cycle (combinational).
  - in_r_data_o = out_r_data_i.
  - Grant push and response pop in the same cycle are both performed; count is unchanged.
- out_r_valid_i=1 with FIFO empty → no in_r_valid_o, err_o set until reset.
- Slave grant-to-r_valid latency >= 1 cycle is required. A response in the grant cycle itself is not supported.
- Occupancy counter is 0..MAX_OUTST wide; pointers wrap modulo MAX_OUTST.

Decomposition:
- Package tcdm_arb_pkg holds:
  - a function computing ID_W from NB_IN;
  - the typedef tcdm_req_t {add, wen, be, data};
  - the typedef tcdm_rsp_t {r_valid, r_data}.
- Sub-module tcdm_arb_id_fifo: synchronous FIFO (push, pop, full, empty, head), parameterised by depth and width.

Test Plan:
- Fairness: in_req_i=4'b1111 held, out_gnt_i=1, 1-cycle response → grants in order 0,1,2,3,0. Each in_r_valid_o[i] appears exactly 1 cycle after its grant.
- Lock: requesters 1 and 2 request; out_gnt_i held low 3 cycles → out_add_o stays equal to requester 1's address for all 3 cycles. Grant goes to 1 on cycle 4, then to 2.
- Backpressure: MAX_OUTST=2, response delay 5 cycles → exactly 2 grants issued, then out_req_o=0 until the first r_valid. The third grant lands in the first cycle after the pop.
- Routing: requester 3 writes 0xDEADBEEF to 0x100 with be=4'hF, then requester 0 reads 0x100. in_r_valid_o[0]=1 and in_r_data_o=0xDEADBEEF; in_r_valid_o[3] pulses only for the write loopback.
- Error and reset: assert out_r_valid_i with the FIFO empty → err_o=1 and no in_r_valid_o. Assert rst_i for 1 cycle with 2 transactions outstanding → busy_o=0, err_o=0, rr_ptr=0. A subsequent stray response sets err_o.
